avalon_ram_arbiter: RTL and testbench



---
 rtl/avalon_arb_pkg.sv | 14 +
 rtl/rr_grant.sv | 24 ++
 rtl/avalon_ram_arbiter.sv | 131 +++++++++++++
 tb/tb_avalon_ram_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/avalon_arb_pkg.sv
// avalon_arb_pkg: shared FSM state and Avalon response codes for the RAM arbiter.
package avalon_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE
    } arb_state_t;

    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [1:0] RESP_RESERVED = 2'b01;
    localparam logic [1:0] RESP_SLVERR   = 2'b10;

endpackage

// File: rtl/rr_grant.sv
// rr_grant: combinational round-robin picker; the first requester at or after ptr_i wins.
module rr_grant #(
    parameter int NUM_HOSTS = 2,
    parameter int IDX_W     = $clog2(NUM_HOSTS)
) (
    input  logic [NUM_HOSTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [NUM_HOSTS-1:0] grant_o,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 any_valid_o
);

    always_comb begin
        idx_o       = '0;
        any_valid_o = |req_i;
        // Scan from the farthest slot back to ptr so the nearest requester is written last.
        for (int k = 0; k < NUM_HOSTS; k++) begin
            if (req_i[(int'(ptr_i) + NUM_HOSTS - 1 - k) % NUM_HOSTS])
                idx_o = IDX_W'((int'(ptr_i) + NUM_HOSTS - 1 - k) % NUM_HOSTS);
        end
        grant_o = any_valid_o ? NUM_HOSTS'(1) << idx_o : '0;
    end

endmodule

// File: rtl/avalon_ram_arbiter.sv
// avalon_ram_arbiter: shares one 1-cycle Avalon RAM agent between NUM_HOSTS hosts, one transaction at a time.
// Define AVALON_ARB_FIXED_PRIORITY_EN for lowest-index-wins instead of round-robin.
module avalon_ram_arbiter
    import avalon_arb_pkg::*;
#(
    parameter int NUM_HOSTS = 2,
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_HOSTS-1:0]        h_read,
    input  logic [NUM_HOSTS-1:0]        h_write,
    input  logic [NUM_HOSTS*ADDR_W-1:0] h_address,
    input  logic [NUM_HOSTS*DATA_W-1:0] h_writedata,
    output logic [NUM_HOSTS-1:0]        h_waitrequest,
    output logic [NUM_HOSTS-1:0]        h_done,
    output logic [DATA_W-1:0]           h_readdata,
    output logic [1:0]                  h_response,
    output logic                        m_read,
    output logic                        m_write,
    output logic [ADDR_W-1:0]           m_address,
    output logic [DATA_W-1:0]           m_writedata,
    input  logic [DATA_W-1:0]           m_readdata,
    input  logic [1:0]                  m_response
);

    localparam int IDX_W = $clog2(NUM_HOSTS);

    arb_state_t             state_q, state_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d, g_q, g_d, idx;
    logic [NUM_HOSTS-1:0]   req, gnt, gnt_q, gnt_d, done_q, done_d;
    logic                   any_req;
    logic                   m_read_q, m_read_d, m_write_q, m_write_d;
    logic [ADDR_W-1:0]      m_address_q, m_address_d;
    logic [DATA_W-1:0]      m_writedata_q, m_writedata_d, rdata_q, rdata_d;
    logic [1:0]             resp_q, resp_d;

    assign req = h_read | h_write;

    rr_grant #(.NUM_HOSTS(NUM_HOSTS), .IDX_W(IDX_W)) u_rr_grant (
        .req_i       (req),
        .ptr_i       (ptr_q),
        .grant_o     (gnt),
        .idx_o       (idx),
        .any_valid_o (any_req)
    );

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        g_d           = g_q;
        gnt_d         = gnt_q;
        m_read_d      = m_read_q;
        m_write_d     = m_write_q;
        m_address_d   = m_address_q;
        m_writedata_d = m_writedata_q;
        rdata_d       = rdata_q;
        resp_d        = resp_q;
        done_d        = '0;
        case (state_q)
            IDLE: begin
                // Skipping the done cycle keeps a just-completed host from being re-granted on a stale request.
                if (any_req && done_q == '0) begin
                    state_d       = ISSUE;
                    g_d           = idx;
                    gnt_d         = gnt;
                    m_read_d      = h_read[idx];
                    m_write_d     = h_write[idx];
                    m_address_d   = h_address[idx*ADDR_W +: ADDR_W];
                    m_writedata_d = h_writedata[idx*DATA_W +: DATA_W];
                end
            end
            ISSUE: begin
                state_d   = CAPTURE;
                m_read_d  = 1'b0;
                m_write_d = 1'b0;
            end
            CAPTURE: begin
                state_d = IDLE;
                rdata_d = m_readdata;
                resp_d  = m_response;
                done_d  = gnt_q;
`ifdef AVALON_ARB_FIXED_PRIORITY_EN
                ptr_d   = '0;
`else
                ptr_d   = (g_q == IDX_W'(NUM_HOSTS - 1)) ? '0 : g_q + 1'b1;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            g_q           <= '0;
            gnt_q         <= '0;
            m_read_q      <= 1'b0;
            m_write_q     <= 1'b0;
            m_address_q   <= '0;
            m_writedata_q <= '0;
            rdata_q       <= '0;
            resp_q        <= RESP_RESERVED;
            done_q        <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            g_q           <= g_d;
            gnt_q         <= gnt_d;
            m_read_q      <= m_read_d;
            m_write_q     <= m_write_d;
            m_address_q   <= m_address_d;
            m_writedata_q <= m_writedata_d;
            rdata_q       <= rdata_d;
            resp_q        <= resp_d;
            done_q        <= done_d;
        end
    end

    assign h_waitrequest = req & ~done_q;
    assign h_done        = done_q;
    assign h_readdata    = rdata_q;
    assign h_response    = resp_q;
    assign m_read        = m_read_q;
    assign m_write       = m_write_q;
    assign m_address     = m_address_q;
    assign m_writedata   = m_writedata_q;

endmodule

// File: tb/tb_avalon_ram_arbiter.sv
// tb_avalon_ram_arbiter: directed vectors plus contention and reset sequences against a behavioural RAM.
module tb_avalon_ram_arbiter;

    localparam int NH = 3;
    localparam int AW = 10;
    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [NH-1:0]    h_read = '0, h_write = '0;
    logic [NH*AW-1:0] h_address = '0;
    logic [NH*DW-1:0] h_writedata = '0;
    logic [NH-1:0]    h_waitrequest, h_done;
    logic [DW-1:0]    h_readdata;
    logic [1:0]       h_response;
    logic             m_read, m_write;
    logic [AW-1:0]    m_address;
    logic [DW-1:0]    m_writedata;
    logic [DW-1:0]    ram_rdata = '0;
    logic [1:0]       ram_resp = 2'b00;
    logic [DW-1:0]    mem [1024];

    int n_tests = 0;
    int n_fail  = 0;

    avalon_ram_arbiter #(.NUM_HOSTS(NH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst           (rst),
        .h_read        (h_read),
        .h_write       (h_write),
        .h_address     (h_address),
        .h_writedata   (h_writedata),
        .h_waitrequest (h_waitrequest),
        .h_done        (h_done),
        .h_readdata    (h_readdata),
        .h_response    (h_response),
        .m_read        (m_read),
        .m_write       (m_write),
        .m_address     (m_address),
        .m_writedata   (m_writedata),
        .m_readdata    (ram_rdata),
        .m_response    (ram_resp)
    );

    always #5 clk = ~clk;

    // Single-port RAM: registered read, read+write together is rejected with SLVERR and writes nothing.
    always @(posedge clk) begin
        if (m_read && m_write) ram_resp <= 2'b10;
        else if (m_write) begin
            mem[m_address] <= m_writedata;
            ram_resp <= 2'b00;
        end else if (m_read) begin
            ram_rdata <= mem[m_address];
            ram_resp <= 2'b00;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic do_txn(input int h, input bit rd, input bit wr, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wd, input bit chk_rd, input logic [DW-1:0] exp_rd,
                          input logic [1:0] exp_resp);
        int lat;
        h_read[h]               = rd;
        h_write[h]              = wr;
        h_address[h*AW +: AW]   = addr;
        h_writedata[h*DW +: DW] = wd;
        lat = 0;
        do begin
            tick();
            lat++;
            if (lat == 1) chk("wait_pending", 32'(h_waitrequest[h]), 32'd1);
        end while (!h_done[h] && lat < 20);
        chk("latency", lat, 3);
        chk("response", 32'(h_response), 32'(exp_resp));
        if (chk_rd) chk("readdata", 32'(h_readdata), 32'(exp_rd));
        chk("wait_at_done", 32'(h_waitrequest[h]), 32'd0);
        h_read[h]  = 1'b0;
        h_write[h] = 1'b0;
        tick();
    endtask

    typedef struct {
        int           h;
        bit           rd;
        bit           wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        bit           chk_rd;
        logic [DW-1:0] exp_rd;
        logic [1:0]   exp_resp;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int exp_h;
        int gap;
        int winner;
        logic [DW-1:0] host_data [NH];
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        vecs[0] = '{0, 1'b0, 1'b1, 10'h010, 8'hA5, 1'b0, 8'h00, 2'b00};
        vecs[1] = '{0, 1'b1, 1'b0, 10'h010, 8'h00, 1'b1, 8'hA5, 2'b00};
        vecs[2] = '{1, 1'b0, 1'b1, 10'h3FF, 8'h3C, 1'b0, 8'h00, 2'b00};
        vecs[3] = '{1, 1'b1, 1'b1, 10'h3FF, 8'hFF, 1'b0, 8'h00, 2'b10};
        vecs[4] = '{2, 1'b1, 1'b0, 10'h3FF, 8'h00, 1'b1, 8'h3C, 2'b00};
        vecs[5] = '{2, 1'b0, 1'b1, 10'h000, 8'h5A, 1'b0, 8'h00, 2'b00};
        vecs[6] = '{0, 1'b1, 1'b0, 10'h000, 8'h00, 1'b1, 8'h5A, 2'b00};
        vecs[7] = '{1, 1'b1, 1'b0, 10'h010, 8'h00, 1'b1, 8'hA5, 2'b00};
        host_data[0] = 8'hA5;
        host_data[1] = 8'h3C;
        host_data[2] = 8'h5A;

        do_reset();
        chk("rst_response", 32'(h_response), 32'h1);
        chk("rst_readdata", 32'(h_readdata), 32'h0);
        chk("rst_done", 32'(h_done), 32'h0);
        chk("rst_mread", 32'(m_read), 32'h0);
        chk("rst_mwrite", 32'(m_write), 32'h0);
        chk("rst_maddr", 32'(m_address), 32'h0);

        for (int i = 0; i < 8; i++)
            do_txn(vecs[i].h, vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd,
                   vecs[i].chk_rd, vecs[i].exp_rd, vecs[i].exp_resp);

        // Contention: all hosts hold reads; a done every 4 cycles after the first (done cycle is skipped).
        do_reset();
        h_address = {10'h000, 10'h3FF, 10'h010};
        h_read    = 3'b111;
        for (int k = 0; k < 6; k++) begin
            gap = 0;
            do begin
                tick();
                gap++;
            end while (h_done == '0 && gap < 20);
`ifdef AVALON_ARB_FIXED_PRIORITY_EN
            exp_h = 0;
`else
            exp_h = k % NH;
`endif
            winner = 0;
            for (int j = NH - 1; j >= 0; j--) if (h_done[j]) winner = j;
            chk("rr_done_onehot", 32'(h_done), 32'(1) << exp_h);
            chk("rr_gap", gap, (k == 0) ? 3 : 4);
            chk("rr_readdata", 32'(h_readdata), 32'(host_data[winner]));
            chk("rr_others_wait", 32'(h_waitrequest), 32'(3'b111 & ~h_done));
        end
        h_read = '0;
        tick();
        tick();

        // Reset during CAPTURE, with the host moving its address after grant.
        do_reset();
        h_read[0]        = 1'b1;
        h_address[0+:AW] = 10'h010;
        tick();
        chk("issue_mread", 32'(m_read), 32'h1);
        chk("issue_maddr", 32'(m_address), 32'h010);
        h_address[0+:AW] = 10'h2AA;
        tick();
        chk("capture_maddr_held", 32'(m_address), 32'h010);
        chk("capture_mread_low", 32'(m_read), 32'h0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_done", 32'(h_done), 32'h0);
        chk("midrst_response", 32'(h_response), 32'h1);
        chk("midrst_mread", 32'(m_read), 32'h0);
        chk("midrst_mwrite", 32'(m_write), 32'h0);
        do_txn(0, 1'b1, 1'b0, 10'h010, 8'h00, 1'b1, 8'hA5, 2'b00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
